// File: rtl/pixel_stream_ctl.sv
// pixel_stream_ctl: streams frame-RAM pixel words MSB-first to a serial bit encoder (valid/ready).
// Optional feature macro PIXEL_BRT_EN adds a registered per-byte brightness scaler ahead of the shifter.
module pixel_stream_ctl #(
   parameter int ADDR_W     = 8,
   parameter int RST_CYCLES = 4000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] cfg_led_num_i,
   input  logic              cfg_mode_i,
   input  logic [7:0]        cfg_brt_i,
   output logic [ADDR_W-1:0] ram_rd_addr_o,
   input  logic [31:0]       ram_rd_data_i,
   output logic              bit_vld_o,
   output logic              bit_data_o,
   input  logic              bit_rdy_i,
   output logic              busy_o,
   output logic              frame_done_o
);

   localparam int CNT_W = $clog2(RST_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_LATCH = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] led_num_q, led_num_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] pix_q, pix_d;
   logic              mode_q, mode_d;
   logic              iss_q, iss_d;
   logic              rd_vld_q, rd_vld_d;
   logic [31:0]       shift_q, shift_d;
   logic [31:0]       buf_q, buf_d;
   logic [4:0]        bit_cnt_q, bit_cnt_d;
   logic              vld_q, vld_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pend_q, pend_d;
   logic [CNT_W-1:0]  lat_q, lat_d;

   logic [31:0]       word_s;
   logic              word_vld_s;
   logic              xfer_s;
   logic              last_bit_s;
   logic [ADDR_W:0]   nxt_addr_s;

   // 24-bit words are left-justified so the serial bit is always shift_q[31]
   function automatic logic [31:0] align_word(input logic [31:0] w, input logic m);
      return m ? w : {w[23:0], 8'h00};
   endfunction

`ifdef PIXEL_BRT_EN
   logic [7:0]  brt_q, brt_d;
   logic [31:0] scl_q, scl_d;
   logic        scl_vld_q, scl_vld_d;

   function automatic logic [7:0] scale_byte(input logic [7:0] b, input logic [7:0] s);
      logic [15:0] p;
      p = {8'h00, b} * ({8'h00, s} + 16'd1);
      return 8'(p >> 8);
   endfunction

   always_comb begin
      scl_d     = {scale_byte(ram_rd_data_i[31:24], brt_q), scale_byte(ram_rd_data_i[23:16], brt_q),
                   scale_byte(ram_rd_data_i[15:8], brt_q),  scale_byte(ram_rd_data_i[7:0], brt_q)};
      scl_vld_d = rd_vld_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         scl_q     <= 32'h0000_0000;
         scl_vld_q <= 1'b0;
         brt_q     <= 8'h00;
      end else begin
         scl_q     <= scl_d;
         scl_vld_q <= scl_vld_d;
         brt_q     <= brt_d;
      end
   end

   assign word_s     = scl_q;
   assign word_vld_s = scl_vld_q;
`else
   logic unused_s;
   assign unused_s   = ^cfg_brt_i;
   assign word_s     = ram_rd_data_i;
   assign word_vld_s = rd_vld_q;
`endif

   assign xfer_s     = vld_q & bit_rdy_i;
   assign last_bit_s = (bit_cnt_q == (mode_q ? 5'd31 : 5'd23));
   assign nxt_addr_s = {1'b0, pix_q} + (ADDR_W + 1)'(2);

   always_comb begin
      state_d   = state_q;
      led_num_d = led_num_q;
      mode_d    = mode_q;
      addr_d    = addr_q;
      pix_d     = pix_q;
      iss_d     = 1'b0;
      rd_vld_d  = iss_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      vld_d     = vld_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      lat_d     = lat_q;
      pend_d    = pend_q | (start_i & (state_q != ST_IDLE));
`ifdef PIXEL_BRT_EN
      brt_d     = brt_q;
`endif
      // Prefetched word lands in the buffer; LOAD consumes its word directly
      if (word_vld_s && (state_q != ST_LOAD)) begin
         buf_d = word_s;
      end else begin
         buf_d = buf_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i || pend_q) begin
               state_d   = ST_FETCH;
               led_num_d = cfg_led_num_i;
               mode_d    = cfg_mode_i;
`ifdef PIXEL_BRT_EN
               brt_d     = cfg_brt_i;
`endif
               addr_d    = '0;
               pix_d     = '0;
               iss_d     = 1'b1;
               busy_d    = 1'b1;
               pend_d    = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (word_vld_s) begin
               shift_d   = align_word(word_s, mode_q);
               bit_cnt_d = 5'd0;
               vld_d     = 1'b1;
               state_d   = ST_SHIFT;
               if (led_num_q != '0) begin
                  addr_d = ADDR_W'(1);
                  iss_d  = 1'b1;
               end else begin
                  addr_d = addr_q;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_SHIFT: begin
            if (xfer_s && last_bit_s) begin
               if (pix_q == led_num_q) begin
                  vld_d   = 1'b0;
                  lat_d   = '0;
                  state_d = ST_LATCH;
               end else begin
                  shift_d   = align_word(buf_q, mode_q);
                  bit_cnt_d = 5'd0;
                  pix_d     = pix_q + ADDR_W'(1);
                  if (nxt_addr_s <= {1'b0, led_num_q}) begin
                     addr_d = nxt_addr_s[ADDR_W-1:0];
                     iss_d  = 1'b1;
                  end else begin
                     addr_d = addr_q;
                  end
               end
            end else if (xfer_s) begin
               shift_d   = {shift_q[30:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 5'd1;
            end else begin
               shift_d = shift_q;
            end
         end
         ST_LATCH: begin
            if (lat_q == CNT_W'(RST_CYCLES - 1)) begin
               done_d  = 1'b1;
               busy_d  = pend_q | start_i;
               state_d = ST_IDLE;
            end else begin
               lat_d = lat_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         led_num_q <= '0;
         mode_q    <= 1'b0;
         addr_q    <= '0;
         pix_q     <= '0;
         iss_q     <= 1'b0;
         rd_vld_q  <= 1'b0;
         shift_q   <= 32'h0000_0000;
         buf_q     <= 32'h0000_0000;
         bit_cnt_q <= 5'd0;
         vld_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pend_q    <= 1'b0;
         lat_q     <= '0;
      end else begin
         state_q   <= state_d;
         led_num_q <= led_num_d;
         mode_q    <= mode_d;
         addr_q    <= addr_d;
         pix_q     <= pix_d;
         iss_q     <= iss_d;
         rd_vld_q  <= rd_vld_d;
         shift_q   <= shift_d;
         buf_q     <= buf_d;
         bit_cnt_q <= bit_cnt_d;
         vld_q     <= vld_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pend_q    <= pend_d;
         lat_q     <= lat_d;
      end
   end

   assign ram_rd_addr_o = addr_q;
   assign bit_vld_o     = vld_q;
   assign bit_data_o    = shift_q[31];
   assign busy_o        = busy_q;
   assign frame_done_o  = done_q;

endmodule

// File: tb/tb_pixel_stream_ctl.sv
// Self-checking bench for pixel_stream_ctl: table-driven frames against a bit-list reference model,
// plus hand sequences for stall, queued restart, mid-frame reset and (PIXEL_BRT_EN) brightness.
module tb_pixel_stream_ctl;
   localparam int ADDR_W  = 8;
   localparam int RST_CYC = 16;
`ifdef PIXEL_BRT_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic        rdy = 1'b0;
   logic [7:0]  led = 8'd0;
   logic [7:0]  brt = 8'hFF;
   logic [7:0]  addr;
   logic [31:0] rdata;
   logic        vld, dat, busy, done;
   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   always @(posedge clk) rdata <= mem[addr];

   pixel_stream_ctl #(.ADDR_W(ADDR_W), .RST_CYCLES(RST_CYC)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_led_num_i(led), .cfg_mode_i(mode),
      .cfg_brt_i(brt), .ram_rd_addr_o(addr), .ram_rd_data_i(rdata), .bit_vld_o(vld),
      .bit_data_o(dat), .bit_rdy_i(rdy), .busy_o(busy), .frame_done_o(done)
   );

   typedef struct {
      logic [7:0]  led;
      logic        mode;
      logic        rdy_rand;
      logic        fixed;
      logic [31:0] w0;
      logic [31:0] w1;
      int          exp_bits;
      int          exp_max;
      logic [63:0] exp_pack;
   } vec_t;

   vec_t tbl [7];
   int   checks = 0;
   int   errors = 0;
   int   cyc, first_v, first_x, last_x, n_done, done1, last_rise, max_addr, busy_gap, stall_err;
   logic prev_vld, track_busy, stall_on, hold_v, hold_d;
   logic got [$];
   logic exp [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference pixel value: each byte scaled by (brt+1)/256 when brightness is enabled
   function automatic logic [31:0] ref_word(input logic [31:0] w, input logic [7:0] b);
`ifdef PIXEL_BRT_EN
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'((int'(w[8*k +: 8]) * (int'(b) + 1)) / 256);
      return r;
`else
      return w | {24'h0, b & 8'h00};
`endif
   endfunction

   task automatic add_frame_exp(input int ledn, input logic m, input logic [7:0] b);
      logic [31:0] w;
      for (int p = 0; p <= ledn; p++) begin
         w = ref_word(mem[p], b);
         for (int i = (m ? 31 : 23); i >= 0; i--) exp.push_back(w[i]);
      end
   endtask

   task automatic clear_stats();
      cyc = 0; first_v = -1; first_x = -1; last_x = -1; n_done = 0; done1 = -1; last_rise = -1;
      max_addr = 0; busy_gap = 0; stall_err = 0; prev_vld = 1'b0; track_busy = 1'b0; stall_on = 1'b0;
      got.delete();
      exp.delete();
   endtask

   task automatic sample();
      cyc++;
      if (vld && rdy) begin
         got.push_back(dat);
         if (first_x < 0) first_x = cyc;
         last_x = cyc;
      end
      if (vld && first_v < 0) first_v = cyc;
      if (vld && !prev_vld) last_rise = cyc;
      prev_vld = vld;
      if (done) begin
         if (n_done == 0) done1 = cyc;
         n_done++;
      end
      if (cyc >= 2 && int'(addr) > max_addr) max_addr = int'(addr);
      if (track_busy && !busy && n_done < 2) busy_gap++;
      if (stall_on && (vld !== hold_v || dat !== hold_d)) stall_err++;
   endtask

   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [7:0] l, input logic m, input logic [7:0] b);
      led = l; mode = m; brt = b; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_bits(input int n, input int budget);
      for (int k = 0; k < budget && got.size() < n; k++) step();
      check("wait_bits", 64'(got.size()), 64'(n));
   endtask

   task automatic check_stream(input string name);
      int mism;
      mism = (got.size() > exp.size()) ? got.size() - exp.size() : exp.size() - got.size();
      for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i]) mism++;
      check({name, "_bit_mismatches"}, 64'(mism), 64'd0);
   endtask

   function automatic logic [63:0] pack_got();
      logic [63:0] pk = 64'd0;
      foreach (got[i]) pk = {pk[62:0], got[i]};
      return pk;
   endfunction

   task automatic run_vec(input vec_t v);
      logic [7:0] b;
      if (v.fixed) begin
         mem[0] = v.w0; mem[1] = v.w1; b = 8'hFF;
      end else begin
         for (int p = 0; p <= int'(v.led); p++) mem[p] = $urandom;
         b = 8'($urandom);
      end
      clear_stats();
      add_frame_exp(int'(v.led), v.mode, b);
      start_frame(v.led, v.mode, b);
      for (int n = 0; n < 20000 && n_done == 0; n++) begin
         rdy = v.rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         step();
      end
      repeat (3) step();
      check("frame_bits", 64'(got.size()), 64'(v.exp_bits));
      check_stream("frame");
      check("max_addr", 64'(max_addr), 64'(v.exp_max));
      check("start_latency", 64'(first_v - 1), 64'(LAT));
      check("latch_gap", 64'(done1 - last_x), 64'(RST_CYC + 1));
      check("frame_done_pulses", 64'(n_done), 64'd1);
      check("busy_after_done", 64'(busy), 64'd0);
      if (!v.rdy_rand) check("no_bubble", 64'(last_x - first_x + 1), 64'(v.exp_bits));
      if (v.fixed) check("fixed_pattern", pack_got(), v.exp_pack);
   endtask

   initial begin
      logic [7:0] b;
      tbl[0] = '{led: 8'd0,   mode: 1'b0, rdy_rand: 1'b0, fixed: 1'b1, w0: 32'h00AA_CCDD, w1: 32'h0,
                 exp_bits: 24,   exp_max: 0,   exp_pack: 64'h0000_0000_00AA_CCDD};
      tbl[1] = '{led: 8'd1,   mode: 1'b1, rdy_rand: 1'b0, fixed: 1'b1, w0: 32'hAAAA_CCCC, w1: 32'h00AA_DDDD,
                 exp_bits: 64,   exp_max: 1,   exp_pack: 64'hAAAA_CCCC_00AA_DDDD};
      tbl[2] = '{led: 8'd3,   mode: 1'b0, rdy_rand: 1'b1, fixed: 1'b0, w0: 32'h0, w1: 32'h0,
                 exp_bits: 96,   exp_max: 3,   exp_pack: 64'h0};
      tbl[3] = '{led: 8'd2,   mode: 1'b1, rdy_rand: 1'b1, fixed: 1'b0, w0: 32'h0, w1: 32'h0,
                 exp_bits: 96,   exp_max: 2,   exp_pack: 64'h0};
      tbl[4] = '{led: 8'd7,   mode: 1'b0, rdy_rand: 1'b1, fixed: 1'b0, w0: 32'h0, w1: 32'h0,
                 exp_bits: 192,  exp_max: 7,   exp_pack: 64'h0};
      tbl[5] = '{led: 8'd255, mode: 1'b0, rdy_rand: 1'b0, fixed: 1'b0, w0: 32'h0, w1: 32'h0,
                 exp_bits: 6144, exp_max: 255, exp_pack: 64'h0};
      tbl[6] = '{led: 8'd5,   mode: 1'b1, rdy_rand: 1'b1, fixed: 1'b0, w0: 32'h0, w1: 32'h0,
                 exp_bits: 192,  exp_max: 5,   exp_pack: 64'h0};
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 64'({addr, vld, dat, busy, done}), 64'd0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 7; i++) run_vec(tbl[i]);

      // Encoder stall mid-pixel: outputs frozen, no bit lost or repeated
      for (int p = 0; p < 2; p++) mem[p] = $urandom;
      b = 8'($urandom);
      clear_stats();
      add_frame_exp(1, 1'b0, b);
      rdy = 1'b1;
      start_frame(8'd1, 1'b0, b);
      wait_bits(5, 100);
      rdy = 1'b0; hold_v = vld; hold_d = dat; stall_on = 1'b1;
      repeat (10) step();
      stall_on = 1'b0;
      check("stall_vld_high", 64'(hold_v), 64'd1);
      check("stall_stable", 64'(stall_err), 64'd0);
      check("stall_no_xfer", 64'(got.size()), 64'd5);
      rdy = 1'b1;
      for (int n = 0; n < 500 && n_done == 0; n++) step();
      check("stall_done", 64'(n_done), 64'd1);
      check_stream("stall");

      // Two starts during SHIFT merge into one queued frame with cfg sampled at restart
      for (int p = 0; p < 2; p++) mem[p] = $urandom;
      b = 8'($urandom);
      clear_stats();
      add_frame_exp(0, 1'b0, b);
      add_frame_exp(1, 1'b1, b);
      rdy = 1'b1;
      start_frame(8'd0, 1'b0, b);
      track_busy = 1'b1;
      wait_bits(3, 100);
      led = 8'd1; mode = 1'b1;
      start = 1'b1; step(); start = 1'b0; step();
      start = 1'b1; step(); start = 1'b0;
      for (int n = 0; n < 1000 && n_done < 2; n++) step();
      repeat (RST_CYC + 60) step();
      check("pend_frames", 64'(n_done), 64'd2);
      check("pend_bits", 64'(got.size()), 64'd88);
      check_stream("pend");
      check("pend_busy_continuous", 64'(busy_gap), 64'd0);
      check("pend_restart_latency", 64'(last_rise - done1), 64'(LAT));

      // Reset at bit 10 of pixel 0 aborts the frame with no frame_done
      for (int p = 0; p < 4; p++) mem[p] = $urandom;
      clear_stats();
      rdy = 1'b1;
      start_frame(8'd3, 1'b0, 8'hFF);
      wait_bits(10, 100);
      rst = 1'b1;
      #1;
      check("abort_outputs", 64'({addr, vld, dat, busy, done}), 64'd0);
      repeat (2) step();
      rst = 1'b0;
      clear_stats();
      repeat (60) step();
      check("abort_no_done", 64'(n_done), 64'd0);
      check("abort_idle_no_vld", 64'(first_v), 64'hFFFF_FFFF_FFFF_FFFF);
      check("abort_idle_busy", 64'(busy), 64'd0);
      run_vec(tbl[2]);

`ifdef PIXEL_BRT_EN
      begin
         logic [7:0]  brt_tab [2];
         logic [63:0] res_tab [2];
         brt_tab[0] = 8'h7F; res_tab[0] = 64'h7F7F00;
         brt_tab[1] = 8'hFF; res_tab[1] = 64'hFFFF00;
         mem[0] = 32'h00FF_FF00;
         for (int i = 0; i < 2; i++) begin
            clear_stats();
            rdy = 1'b1;
            start_frame(8'd0, 1'b0, brt_tab[i]);
            for (int n = 0; n < 500 && n_done == 0; n++) step();
            check("brt_done", 64'(n_done), 64'd1);
            check("brt_pattern", pack_got(), res_tab[i]);
         end
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
